// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int LANES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              out_level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CTRL_W-1:0]       main_ctrl;
  logic [LANES*DATA_W-1:0] main_data;

  logic in_fire;
  logic out_fire;
  logic load_main;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign out_level = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0]       skid_ctrl;
  logic [LANES*DATA_W-1:0] skid_data;
  logic                    load_skid;
  logic                    main_from_skid;
  logic                    rdy_q;

  assign in_ready = rdy_q;

  // Occupancy transitions with skid; flush wins over normal moves.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Registered ready: low only while both entries are held.
  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b1;
    else     rdy_q <= (state_nxt != TWO);
  end

  // Skid entry captures the input arriving while the head stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // Head entry loads from input or promotes the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (main_from_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end
`else
  assign in_ready = !out_valid | out_ready;

  // Single-register occupancy; in_fire while full implies out_fire.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire) begin
          load_main = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
    end
  end

  // Head entry loads from the input on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end
  end
`endif

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks for pipe_stage_reg.
// Covers reset, streaming, stall, flush, bubble and mid-stream reset.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 32;
  localparam int LN = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   in_ctrl;
  logic [LN*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_ctrl;
  logic [LN*DW-1:0] out_data;
  logic [1:0]      out_level;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .LANES(LN)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .out_level(out_level)
  );

  always #5 clk = ~clk;

  function automatic logic [LN*DW-1:0] mk(input logic [DW-1:0] b);
    mk = {b + 32'h200, b + 32'h100, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (out_ctrl !== 8'h00) begin
      errors++; $display("FAIL rst_ctrl got=%0h exp=0", out_ctrl);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL rst_data got=%0h exp=0", out_data);
    end
    checks++;
    if (out_level !== 2'd0) begin
      errors++; $display("FAIL rst_level got=%0d exp=0", out_level);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_ctrl = CW'(i);
      in_data = mk(DW'(i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== mk(DW'(i)) ||
          out_ctrl !== CW'(i)) begin
        errors++;
        $display("FAIL stream_%0d got v=%0b c=%0h d=%0h exp v=1 c=%0h d=%0h",
                 i, out_valid, out_ctrl, out_data, i, mk(DW'(i)));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_level !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain got v=%0b l=%0d exp v=0 l=0",
               out_valid, out_level);
    end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = mk(32'h11);
    step();
    checks++;
    if (out_level !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_one got l=%0d r=%0b exp l=1 r=1", out_level, in_ready);
    end
    in_ctrl = 8'h02; in_data = mk(32'h22);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_level !== 2'd2 || in_ready !== 1'b0 || out_data !== mk(32'h11)) begin
      errors++;
      $display("FAIL stall_two got l=%0d r=%0b d=%0h exp l=2 r=0 d=%0h",
               out_level, in_ready, out_data, mk(32'h11));
    end
    step();
    checks++;
    if (out_data !== mk(32'h11) || out_level !== 2'd2) begin
      errors++;
      $display("FAIL stall_hold got d=%0h l=%0d exp d=%0h l=2",
               out_data, out_level, mk(32'h11));
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== mk(32'h22) || out_ctrl !== 8'h02 ||
        out_level !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel got d=%0h c=%0h l=%0d r=%0b exp d=%0h c=2 l=1 r=1",
               out_data, out_ctrl, out_level, in_ready, mk(32'h22));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_level !== 2'd0) begin
      errors++;
      $display("FAIL stall_empty got v=%0b l=%0d exp v=0 l=0", out_valid, out_level);
    end
  endtask
`else
  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h03; in_data = mk(32'h30);
    step();
    checks++;
    if (out_level !== 2'd1 || in_ready !== 1'b0 || out_data !== mk(32'h30)) begin
      errors++;
      $display("FAIL stall_one got l=%0d r=%0b d=%0h exp l=1 r=0 d=%0h",
               out_level, in_ready, out_data, mk(32'h30));
    end
    in_ctrl = 8'h04; in_data = mk(32'h33);
    step();
    checks++;
    if (out_data !== mk(32'h30) || out_ctrl !== 8'h03 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got d=%0h c=%0h r=%0b exp d=%0h c=3 r=0",
               out_data, out_ctrl, in_ready, mk(32'h30));
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_comb_ready got=%0b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== mk(32'h33) || out_ctrl !== 8'h04 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel got v=%0b d=%0h c=%0h exp v=1 d=%0h c=4",
               out_valid, out_data, out_ctrl, mk(32'h33));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_level !== 2'd0) begin
      errors++;
      $display("FAIL stall_empty got v=%0b l=%0d exp v=0 l=0", out_valid, out_level);
    end
  endtask
`endif

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = mk(32'h40);
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_ctrl = 8'h06; in_data = mk(32'h41);
    step();
`endif
    flush = 1'b1; in_ctrl = 8'h07; in_data = mk(32'h44);
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_level !== 2'd0) begin
      errors++;
      $display("FAIL flush got v=%0b c=%0h l=%0d exp v=0 c=0 l=0",
               out_valid, out_ctrl, out_level);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
      errors++;
      $display("FAIL flush_after got v=%0b c=%0h exp v=0 c=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = mk(32'h50);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_ctrl !== 8'hFF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bubble_head got v=%0b c=%0h exp v=1 c=ff", out_valid, out_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_ctrl !== 8'h00 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bubble_%0d got v=%0b c=%0h exp v=0 c=0",
                 i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h08; in_data = mk(32'h54);
    step();
    checks++;
    if (out_level !== 2'd1) begin
      errors++; $display("FAIL rmid_pre got l=%0d exp l=1", out_level);
    end
    rst = 1'b1; out_ready = 1'b1; in_ctrl = 8'h09; in_data = mk(32'h55);
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== '0 ||
        out_level !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid got v=%0b c=%0h d=%0h l=%0d r=%0b exp v=0 c=0 d=0 l=0 r=1",
               out_valid, out_ctrl, out_data, out_level, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rmid_after got v=%0b d=%0h exp v=0 d=0", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the 5-stage MIPS core: the generalised successor of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one control bundle and a configurable number of data lanes per entry. It adds a valid/ready handshake for stalls, a synchronous flush that inserts a bubble, and an optional 2-entry skid buffer so that `in_ready` is registered. It sits between any two pipeline stages; the hazard unit drives `flush` and the downstream stage drives `out_ready`.

## Interface
- `CTRL_W`, default 8: control bundle width (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp, RegDst packed by the instantiating stage).
- `DATA_W`, default 32: width of one data lane.
- `LANES`, default 3: number of data lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous flush; squashes all held entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  LANES*DATA_W  upstream data lanes.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry (low = stall).
- `out_ctrl`  out  CTRL_W  head control bundle; forced to 0 whenever `out_valid`=0.
- `out_data`  out  LANES*DATA_W  head data lanes.
- `out_level`  out  2  number of held entries (0..2).

## Operation
- `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Occupancy states: EMPTY (0 entries), ONE (main register full), TWO (main + skid full; skid build only).
- EMPTY: `in_fire` → ONE, main ← in.
- ONE: `in_fire` & !`out_fire` → TWO, skid ← in. !`in_fire` & `out_fire` → EMPTY. Both → ONE, main ← in. Neither → hold.
- TWO: `out_fire` → ONE, main ← skid. No input is accepted (`in_ready`=0).
- Bubble rule: `out_ctrl` = 0 whenever `out_valid`=0, so downstream sees NOP controls. `out_data` holds its last value and has no meaning when invalid.
- Flush: state → EMPTY and all entries are dropped. An `in_fire` in the same cycle is consumed and discarded. Priority is `rst` > `flush` > normal transitions.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid` (entry visible the cycle after the accepting edge).
- Throughput: 1 entry/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `out_level`=0, `in_ready`=1 (both builds). Inputs during `rst` are ignored.
- Reset mid-operation: all entries are discarded on the reset edge, identical to flush, plus data is zeroed.
- Skid build: `in_ready` is a flop output, = (next state != TWO). There is no combinational path from `out_ready` to `in_ready`.
- Stall: with `out_ready`=0, `out_valid`, `out_ctrl` and `out_data` remain stable until `out_fire`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: 2-entry skid buffer as above; `out_level` ranges 0..2; `in_ready` is registered.
- Not defined: single register, states EMPTY/ONE only. `in_ready` = !`out_valid` | `out_ready` (combinational). `out_level` ∈ {0,1}. The stage behaves as a classic stallable pipeline register.
- All other behaviour (flush, bubble, reset) is identical in both builds.

## Test plan
- Streaming: LANES=3, `out_ready`=1, 10 back-to-back entries with data 0x1..0xA → `out_data` lane0 = 0x1..0xA on consecutive cycles, starting 1 cycle after the first accept; no gaps.
- Stall/skid (macro on): accept 0x11, 0x22 with `out_ready`=0 → `out_level`=2, `in_ready`=0, head stays 0x11. Raise `out_ready` → 0x11 then 0x22 out; `in_ready` returns to 1 the cycle after the first `out_fire`.
- Stall (macro off): hold `out_ready`=0 with an entry held → `in_ready`=0 in the same cycle; an upstream entry 0x33 is not lost and appears after release.
- Flush: `out_level`=2, assert `flush` together with `in_valid` carrying 0x44 → next cycle `out_valid`=0, `out_ctrl`=0, `out_level`=0; 0x44 is never output.
- Bubble: `in_ctrl`=0xFF accepted, then `in_valid`=0 for 3 cycles with `out_ready`=1 → `out_ctrl`=0xFF for one cycle, then 0x00 for 3 cycles.
- Reset mid-stream: assert `rst` for 1 cycle with `out_level`=1 → outputs reach reset values; `in_valid` during `rst` is not accepted.
